// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N-channel key debouncer with press/release/long-press
// pulses and an optional auto-repeat (build with KEY_REPEAT_EN defined).
// Each channel is an independent key_debounce_chan instance.

module key_debounce_chan #(
    parameter int ACTIVE_LOW = 1,
    parameter int CNT_MAX    = 999_999,
    parameter int CNT_W      = 20,
    parameter int LONG_MAX   = 49_999_999,
    parameter int LONG_W     = 26,
    parameter int REPEAT_MAX = 9_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_raw,
    output logic key_state,
    output logic press_flag,
    output logic release_flag,
    output logic long_flag,
    output logic repeat_flag
);
    typedef enum logic [1:0] {IDLE, PRESS_DEB, PRESSED, RELEASE_DEB} state_t;

    localparam logic              INACT   = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0]  D_TC    = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0]  D_ONE   = CNT_W'(1);
    localparam logic [LONG_W-1:0] L_TC    = LONG_W'(LONG_MAX);
    localparam logic [LONG_W-1:0] L_ONE   = LONG_W'(1);

    // Terminal counts must fit the counters; stop elaboration otherwise.
    if (longint'(CNT_MAX) >= (64'd1 << CNT_W) || longint'(LONG_MAX) >= (64'd1 << LONG_W) ||
        longint'(REPEAT_MAX) >= (64'd1 << LONG_W)) begin : g_param_err
        $error("key_debounce_chan: terminal count does not fit counter width");
    end

    logic [1:0]        sync_q, sync_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;
    logic [LONG_W-1:0] lcnt_q, lcnt_d;
    logic              long_done_q, long_done_d;
    logic              key_state_q, key_state_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              act;
`ifdef KEY_REPEAT_EN
    localparam logic [LONG_W-1:0] R_TC = LONG_W'(REPEAT_MAX);
    logic              repeat_q, repeat_d;
`endif

    // Polarity is normalised after the second synchroniser stage.
    assign sync_d = {sync_q[0], key_raw};
    assign act    = sync_q[1] ^ INACT;

    // State register: synchroniser, FSM, counters and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync_q      <= {2{INACT}};
            state_q     <= IDLE;
            dcnt_q      <= '0;
            lcnt_q      <= '0;
            long_done_q <= 1'b0;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_q    <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            lcnt_q      <= lcnt_d;
            long_done_q <= long_done_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
`ifdef KEY_REPEAT_EN
            repeat_q    <= repeat_d;
`endif
        end
    end

    // Next state plus debounce and hold timers; lcnt doubles as the repeat timer.
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        lcnt_d      = lcnt_q;
        long_done_d = long_done_q;
        long_d      = 1'b0;
`ifdef KEY_REPEAT_EN
        repeat_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                dcnt_d      = '0;
                lcnt_d      = '0;
                long_done_d = 1'b0;
                if (act) state_d = PRESS_DEB;
            end
            PRESS_DEB: begin
                if (!act) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == D_TC) begin
                    state_d     = PRESSED;
                    dcnt_d      = '0;
                    lcnt_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + D_ONE;
                end
            end
            PRESSED: begin
                if (!act) begin
                    state_d = RELEASE_DEB;
                    dcnt_d  = '0;
                end else if (!long_done_q) begin
                    // Long pulse fires on the first cycle lcnt sits at LONG_MAX.
                    if (lcnt_q == L_TC) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
`ifdef KEY_REPEAT_EN
                        lcnt_d      = '0;
`endif
                    end else begin
                        lcnt_d = lcnt_q + L_ONE;
                    end
                end
`ifdef KEY_REPEAT_EN
                else if (lcnt_q == R_TC) begin
                    repeat_d = 1'b1;
                    lcnt_d   = '0;
                end else begin
                    lcnt_d = lcnt_q + L_ONE;
                end
`endif
            end
            RELEASE_DEB: begin
                if (act) begin
                    state_d = PRESSED;
                    dcnt_d  = '0;
                end else if (dcnt_q == D_TC) begin
                    state_d     = IDLE;
                    dcnt_d      = '0;
                    lcnt_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + D_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the transition so flags align with key_state.
    always_comb begin
        key_state_d = (state_d == PRESSED) || (state_d == RELEASE_DEB);
        press_d     = (state_q == PRESS_DEB) && (state_d == PRESSED);
        release_d   = (state_q == RELEASE_DEB) && (state_d == IDLE);
    end

    assign key_state    = key_state_q;
    assign press_flag   = press_q;
    assign release_flag = release_q;
    assign long_flag    = long_q;
`ifdef KEY_REPEAT_EN
    assign repeat_flag  = repeat_q;
`else
    assign repeat_flag  = 1'b0;
`endif
endmodule

module key_debounce_multi #(
    parameter int KEY_NUM    = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int CNT_MAX    = 999_999,
    parameter int CNT_W      = 20,
    parameter int LONG_MAX   = 49_999_999,
    parameter int LONG_W     = 26,
    parameter int REPEAT_MAX = 9_999_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] press_flag,
    output logic [KEY_NUM-1:0] release_flag,
    output logic [KEY_NUM-1:0] long_flag,
    output logic [KEY_NUM-1:0] repeat_flag
);
    // One fully independent channel per key.
    for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
        key_debounce_chan #(
            .ACTIVE_LOW (ACTIVE_LOW),
            .CNT_MAX    (CNT_MAX),
            .CNT_W      (CNT_W),
            .LONG_MAX   (LONG_MAX),
            .LONG_W     (LONG_W),
            .REPEAT_MAX (REPEAT_MAX)
        ) u_chan (
            .sys_clk      (sys_clk),
            .sys_rst_n    (sys_rst_n),
            .key_raw      (key_in[i]),
            .key_state    (key_state[i]),
            .press_flag   (press_flag[i]),
            .release_flag (release_flag[i]),
            .long_flag    (long_flag[i]),
            .repeat_flag  (repeat_flag[i])
        );
    end
endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: table-driven key_state checks plus a flag
// scoreboard; every flag is predicted when the stimulus is driven.
module tb_key_debounce_multi;
    localparam int LAT = 13;   // CNT_MAX + 4 with CNT_MAX = 9

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] key_in = 4'b0000;
    logic [3:0] key_state, press_flag, release_flag, long_flag, repeat_flag;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // kind: 0 press, 1 release, 2 long, 3 repeat
    typedef struct {
        int         cyc;
        int         kind;
        logic [3:0] mask;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic [3:0] key;
        int         hold;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] state;
    } vec_t;

    key_debounce_multi #(
        .KEY_NUM(4), .ACTIVE_LOW(1), .CNT_MAX(9), .CNT_W(20),
        .LONG_MAX(49), .LONG_W(26), .REPEAT_MAX(19)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_in       (key_in),
        .key_state    (key_state),
        .press_flag   (press_flag),
        .release_flag (release_flag),
        .long_flag    (long_flag),
        .repeat_flag  (repeat_flag)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Every cycle: flags seen must equal the flags scheduled for this edge.
    always @(negedge sys_clk) begin
        logic [3:0] e [4];
        if (chk_en) begin
            for (int k = 0; k < 4; k++) e[k] = 4'b0000;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    e[sb[i].kind] = e[sb[i].kind] | sb[i].mask;
                    sb.delete(i);
                end
            end
            n_tests++;
            if ({press_flag, release_flag, long_flag, repeat_flag} !== {e[0], e[1], e[2], e[3]}) begin
                n_fail++;
                $display("FAIL flags@%0d: got p=%b r=%b l=%b q=%b, expected p=%b r=%b l=%b q=%b",
                         cyc, press_flag, release_flag, long_flag, repeat_flag, e[0], e[1], e[2], e[3]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic push(input int off, input int kind, input logic [3:0] m);
        ev_t ev;
        if (m != 4'b0000) begin
            ev.cyc  = cyc + off;
            ev.kind = kind;
            ev.mask = m;
            sb.push_back(ev);
        end
    endtask

    task automatic check_state(input string name, input logic [3:0] exp);
        n_tests++;
        if (key_state !== exp) begin
            n_fail++;
            $display("FAIL %s@%0d: key_state=%b expected %b", name, cyc, key_state, exp);
        end
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if ({key_state, press_flag, release_flag, long_flag, repeat_flag} !== 20'h0) begin
            n_fail++;
            $display("FAIL %s@%0d: outputs s=%b p=%b r=%b l=%b q=%b expected all 0",
                     name, cyc, key_state, press_flag, release_flag, long_flag, repeat_flag);
        end
    endtask

    initial begin
        vec_t vec [13];
        // Clean press/release on key0.
        vec[0]  = '{4'b1110, 12, 4'b0001, 4'b0000, 4'b0000};
        vec[1]  = '{4'b1110,  1, 4'b0000, 4'b0000, 4'b0001};
        vec[2]  = '{4'b1110, 27, 4'b0000, 4'b0000, 4'b0001};
        vec[3]  = '{4'b1111, 12, 4'b0000, 4'b0001, 4'b0001};
        vec[4]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000};
        vec[5]  = '{4'b1111, 10, 4'b0000, 4'b0000, 4'b0000};
        // Keys 0 and 3 pressed, 5-cycle release glitch on key3, joint release.
        vec[6]  = '{4'b0110, 13, 4'b1001, 4'b0000, 4'b1001};
        vec[7]  = '{4'b0110,  7, 4'b0000, 4'b0000, 4'b1001};
        vec[8]  = '{4'b1110,  5, 4'b0000, 4'b0000, 4'b1001};
        vec[9]  = '{4'b0110,  5, 4'b0000, 4'b0000, 4'b1001};
        vec[10] = '{4'b1111, 12, 4'b0000, 4'b1001, 4'b1001};
        vec[11] = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000};
        vec[12] = '{4'b1111, 10, 4'b0000, 4'b0000, 4'b0000};

        // Reset held 3 edges with every key pressed.
        tick(1);
        chk_en = 1'b1;
        check_zero("reset_e1");
        tick(1);
        check_zero("reset_e2");
        tick(1);
        check_zero("reset_e3");
        sys_rst_n = 1'b1;
        push(LAT, 0, 4'b1111);
        tick(LAT - 1);
        check_state("post_rst_pre", 4'b0000);
        tick(1);
        check_state("post_rst_press", 4'b1111);
        key_in = 4'b1111;
        push(LAT, 1, 4'b1111);
        tick(LAT);
        check_state("post_rst_rel", 4'b0000);
        tick(5);

        for (int i = 0; i < 13; i++) begin
            key_in = vec[i].key;
            push(LAT, 0, vec[i].press);
            push(LAT, 1, vec[i].rel);
            tick(vec[i].hold);
            check_state($sformatf("vec%0d", i), vec[i].state);
        end

        // Bounce on key1: 5 low / 1 high never completes a debounce.
        for (int p = 0; p < 10; p++) begin
            key_in = 4'b1101;
            tick(5);
            key_in = 4'b1111;
            tick(1);
        end
        check_state("bounce", 4'b0000);
        key_in = 4'b1101;
        push(LAT, 0, 4'b0010);
        tick(LAT);
        check_state("bounce_hold", 4'b0010);
        key_in = 4'b1111;
        push(LAT, 1, 4'b0010);
        tick(LAT);
        check_state("bounce_rel", 4'b0000);
        tick(5);

        // Long press on key2 held 200 cycles.
        key_in = 4'b1011;
        push(LAT, 0, 4'b0100);
        push(63, 2, 4'b0100);
`ifdef KEY_REPEAT_EN
        for (int t = 83; t < 200; t += 20) push(t, 3, 4'b0100);
`endif
        tick(LAT);
        check_state("long_press", 4'b0100);
        tick(200 - LAT);
        key_in = 4'b1111;
        push(LAT, 1, 4'b0100);
        tick(LAT);
        check_state("long_rel", 4'b0000);
        tick(5);

        // Reset in the middle of key0 press debounce (dcnt = 5).
        key_in = 4'b1110;
        tick(8);
        sys_rst_n = 1'b0;
        tick(1);
        check_zero("midrst");
        sys_rst_n = 1'b1;
        push(LAT, 0, 4'b0001);
        tick(LAT - 1);
        check_state("midrst_pre", 4'b0000);
        tick(1);
        check_state("midrst_press", 4'b0001);
        key_in = 4'b1111;
        push(LAT, 1, 4'b0001);
        tick(LAT);
        check_state("midrst_rel", 4'b0000);
        tick(20);

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d events never seen, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised N-channel debouncer; successor to the single-key 20 ms filter.
- Per key: synchronises the raw input and debounces both press and release edges.
- Per key: produces a debounced level, single-cycle press, release and long-press pulses, and optional auto-repeat pulses.
- Sits between board push-buttons and control FSMs (AD7606 start, mode select, display paging).

Parameters:
- KEY_NUM, 4, number of independent key channels.
- ACTIVE_LOW, 1, 1 means a pressed key reads 0 on key_in; 0 means pressed reads 1.
- CNT_MAX, 999_999, debounce terminal count (20 ms at 50 MHz).
- CNT_W, 20, debounce counter width; must hold CNT_MAX.
- LONG_MAX, 49_999_999, long-press terminal count (1 s at 50 MHz).
- LONG_W, 26, long-press counter width; must hold LONG_MAX and REPEAT_MAX.
- REPEAT_MAX, 9_999_999, auto-repeat period minus 1 (200 ms); used only with KEY_REPEAT_EN.

Ports:
- sys_clk, input, 1, system clock, 50 MHz.
- sys_rst_n, input, 1, reset: synchronous, active-low.
- key_in, input, KEY_NUM, raw asynchronous key pins.
- key_state, output, KEY_NUM, debounced level; 1 = pressed.
- press_flag, output, KEY_NUM, one-cycle pulse on a debounced press.
- release_flag, output, KEY_NUM, one-cycle pulse on a debounced release.
- long_flag, output, KEY_NUM, one-cycle pulse once per press when the hold time reaches LONG_MAX.
- repeat_flag, output, KEY_NUM, one-cycle auto-repeat pulses; tied to 0 without KEY_REPEAT_EN.

Behaviour:
- Reset is synchronous: sampled only on the sys_clk rising edge while sys_rst_n=0.
- Reset values:
  - Synchroniser flops load the inactive level (1 if ACTIVE_LOW, else 0).
  - All FSMs go to IDLE; all counters are 0.
  - All outputs are 0.
- Synchroniser: 2 flops per key. Polarity is normalised after stage 2, giving act[i] (1 = pressed).
- Channels are fully independent: one FSM, one debounce counter (CNT_W) and one long counter (LONG_W) per key. Any number of keys may be active or flag on the same cycle.
- FSM per key (states IDLE, PRESS_DEB, PRESSED, RELEASE_DEB):
  - IDLE: on act=1, go to PRESS_DEB with dcnt=0. lcnt is held at 0.
  - PRESS_DEB: on act=0, return to IDLE with dcnt=0 (glitch rejected, no flag). If act=1 and dcnt==CNT_MAX, go to PRESSED, pulse press_flag, dcnt=0, lcnt=0. Otherwise dcnt+1.
  - PRESSED: on act=0, go to RELEASE_DEB with dcnt=0. Otherwise lcnt saturates: it increments until it equals LONG_MAX, then holds. long_flag pulses on the cycle lcnt transitions to LONG_MAX, so at most once per press.
  - RELEASE_DEB: on act=1, return to PRESSED with dcnt=0; lcnt is held, not cleared. If act=0 and dcnt==CNT_MAX, go to IDLE, pulse release_flag, lcnt=0. Otherwise dcnt+1.
- key_state=1 in PRESSED and RELEASE_DEB; 0 otherwise. It is registered and rises on the same edge as press_flag.
- All flags are registered and high for exactly 1 cycle.
- Latency, press: press_flag rises on edge CNT_MAX+4, counted from the first edge that samples the raw active level. This is 2 synchroniser edges, 1 IDLE edge and CNT_MAX+1 debounce edges.
- Latency, release: release_flag rises on edge CNT_MAX+4 after the raw release is first sampled.
- Bounce shorter than CNT_MAX+1 consecutive cycles never produces a flag.
- Release and press are never flagged on the same cycle for one key.
- Reset asserted mid-operation: on the next edge all state returns to the reset values, and any in-flight flag is dropped. A key held through reset re-debounces from IDLE and yields a fresh press_flag.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - After long_flag, while the key stays in PRESSED, repeat_flag pulses every REPEAT_MAX+1 cycles.
  - The first repeat pulse comes REPEAT_MAX+1 cycles after long_flag.
  - The repeat timer reuses lcnt: it reloads to 0 on each pulse, and a long-done bit per key marks that the long phase has ended.
  - The repeat timer pauses in RELEASE_DEB.
  - No repeat pulse occurs on the release cycle.
- Not defined: the repeat logic is absent, repeat_flag is a constant 0, and lcnt saturates as described above.

Test Plan:
- Bench parameters for all scenarios: KEY_NUM=4, CNT_MAX=9, LONG_MAX=49, REPEAT_MAX=19, ACTIVE_LOW=1.
- Reset: hold sys_rst_n=0 for 3 edges with key_in=4'b0000 -> every output is 0. After release, with key_in low held, press_flag on all 4 keys at edge 13.
- Clean press on key0: key_in[0] driven low at edge 0 and held -> press_flag[0]=1 only at edge 13, key_state[0]=1 from edge 13. key_in[0] driven high at edge 40 -> release_flag[0] at edge 53, key_state[0]=0.
- Bounce on key1: key_in[1] toggles low 5 cycles, high 1 cycle, repeating for 60 cycles -> no flags on key1. Then held low -> press_flag[1] at edge 13 after the hold begins.
- Long press and repeat on key2:
  - key_in[2] held low for 200 cycles -> press_flag at edge 13, long_flag 50 edges later (edge 63), once only.
  - With KEY_REPEAT_EN: repeat_flag at edges 83, 103, 123, ...
  - Without KEY_REPEAT_EN: repeat_flag stays 0.
- Release glitch plus simultaneity:
  - Key3 pressed, then a 5-cycle high glitch -> no release_flag, key_state[3] stays 1.
  - Keys 0 and 3 released on the same edge -> both release_flags pulse on the same cycle.
- Mid-operation reset: assert reset at press-debounce count 5 on key0 -> no flag. After deassertion, with the key still low, press_flag comes 13 edges later.
